touch_pad_debounce: RTL and testbench

Input-side conditioner for the Fomu touch pads and EVT buttons. These are pulled-up inputs, and touching or pressing a pad pulls it low.
- Synchronises each raw active-low pad into the clk domain and debounces it.
- Emits a clean level plus one-cycle press, release and long-press events.
- Sits between the SB_IO pulled inputs and LED/control logic, replacing direct use of raw `~user_n_pulled` levels.

---
 rtl/touch_pad_debounce_pkg.sv | 20 ++
 rtl/touch_pad_channel.sv | 136 +++++++++++++
 rtl/touch_pad_debounce.sv | 43 ++++
 tb/tb_touch_pad_debounce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pad_debounce_pkg.sv
// Shared definitions for the touch pad / button conditioner.
package touch_pad_debounce_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } pad_state_t;

  // A level change must hold for 2**DEBOUNCE_LOG2 clocks to be accepted.
  localparam int DEBOUNCE_LOG2_DEFAULT   = 16;
  // A confirmed hold of 2**LONG_PRESS_LOG2 clocks raises the long-press event.
  localparam int LONG_PRESS_LOG2_DEFAULT = 24;

  // Pads are pulled up; touching or pressing pulls them low.
  localparam logic PAD_ACTIVE = 1'b0;

endpackage

// File: rtl/touch_pad_channel.sv
// One pad channel: two-flop synchroniser, debounce FSM, hold timer and
// registered one-cycle event strobes.
module touch_pad_channel
  import touch_pad_debounce_pkg::*;
#(
  parameter int DEBOUNCE_LOG2   = DEBOUNCE_LOG2_DEFAULT,
  parameter int LONG_PRESS_LOG2 = LONG_PRESS_LOG2_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic pad_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  logic [1:0]                 sync_d, sync_q;
  pad_state_t                 state_d, state_q;
  logic [DEBOUNCE_LOG2-1:0]   db_cnt_d, db_cnt_q;
  logic [LONG_PRESS_LOG2-1:0] hold_cnt_d, hold_cnt_q;
  logic                       long_done_d, long_done_q;
  logic                       pressed_d, pressed_q;
  logic                       press_d, press_q;
  logic                       release_d, release_q;
  logic                       long_d, long_q;
  logic                       pad_active;

  // Shift the raw pad through two stages; stage 1 is the clean sample.
  always_comb begin
    sync_d = {sync_q[0], pad_n};
  end

  assign pad_active = (sync_q[1] == PAD_ACTIVE);

  // Next-state logic: confirm each level change, time the hold, raise strobes.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    pressed_d   = pressed_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    if (!enable) begin
      // Disabled channels drop straight to idle with no release event.
      state_d     = IDLE;
      db_cnt_d    = '0;
      hold_cnt_d  = '0;
      long_done_d = 1'b0;
      pressed_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pad_active) begin
            state_d  = CONFIRM_PRESS;
            db_cnt_d = '0;
          end
        end
        CONFIRM_PRESS: begin
          if (!pad_active) begin
            state_d = IDLE;
          end else if (&db_cnt_q) begin
            state_d     = HELD;
            pressed_d   = 1'b1;
            press_d     = 1'b1;
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!pad_active) begin
            state_d  = CONFIRM_RELEASE;
            db_cnt_d = '0;
          end else if (!long_done_q) begin
            // Saturate at the threshold so the long event fires only once.
            if (&hold_cnt_q) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        CONFIRM_RELEASE: begin
          // hold_cnt is left untouched so a bounced release resumes the timer.
          if (pad_active) begin
            state_d = HELD;
          end else if (&db_cnt_q) begin
            state_d   = IDLE;
            pressed_d = 1'b0;
            release_d = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; synchroniser resets to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      pressed_q   <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      pressed_q   <= pressed_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: rtl/touch_pad_debounce.sv
// Multi-pad conditioner: one independent debounce channel per pad plus a
// combined "any pad held" level.
module touch_pad_debounce
  import touch_pad_debounce_pkg::*;
#(
  parameter int N_PADS          = 2,
  parameter int DEBOUNCE_LOG2   = DEBOUNCE_LOG2_DEFAULT,
  parameter int LONG_PRESS_LOG2 = LONG_PRESS_LOG2_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_PADS-1:0] pad_n,
  output logic [N_PADS-1:0] pressed,
  output logic [N_PADS-1:0] press_pulse,
  output logic [N_PADS-1:0] release_pulse,
  output logic [N_PADS-1:0] long_pulse,
  output logic              any_pressed
);

  genvar gi;
  generate
    for (gi = 0; gi < N_PADS; gi++) begin : g_ch
      touch_pad_channel #(
        .DEBOUNCE_LOG2  (DEBOUNCE_LOG2),
        .LONG_PRESS_LOG2(LONG_PRESS_LOG2)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pad_n        (pad_n[gi]),
        .pressed      (pressed[gi]),
        .press_pulse  (press_pulse[gi]),
        .release_pulse(release_pulse[gi]),
        .long_pulse   (long_pulse[gi])
      );
    end
  endgenerate

  // Derived from registered levels only, so no path from the raw pads.
  assign any_pressed = |pressed;

endmodule

// File: tb/tb_touch_pad_debounce.sv
// Bench for touch_pad_debounce with short debounce/long-press windows.
module tb_touch_pad_debounce;

  localparam int NP          = 2;
  localparam int DB          = 4;
  localparam int LP          = 6;
  localparam int CONFIRM_RUN = (1 << DB) + 1;  // consecutive clean samples to accept
  localparam int LONG_EDGES  = 1 << LP;        // steady held samples to long-press

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic [NP-1:0] pad_n = '1;
  logic [NP-1:0] pressed, press_pulse, release_pulse, long_pulse;
  logic          any_pressed;

  touch_pad_debounce #(
    .N_PADS         (NP),
    .DEBOUNCE_LOG2  (DB),
    .LONG_PRESS_LOG2(LP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .pad_n        (pad_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .any_pressed  (any_pressed)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: sample history, run lengths and a held-sample count.
  logic [NP-1:0] m_s1 = '1, m_s2 = '1, m_prev = '1;
  logic [NP-1:0] m_conf = '0, m_ldone = '0;
  logic [NP-1:0] m_pp = '0, m_rp = '0, m_lp = '0;
  int            m_run[NP];
  int            m_held[NP];

  initial begin : model
    logic s_act;
    for (int c = 0; c < NP; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = '1; m_s2 = '1; m_prev = '1;
        m_conf = '0; m_ldone = '0;
        m_pp = '0; m_rp = '0; m_lp = '0;
        for (int c = 0; c < NP; c++) begin
          m_run[c]  = 0;
          m_held[c] = 0;
        end
      end else begin
        m_pp = '0; m_rp = '0; m_lp = '0;
        for (int c = 0; c < NP; c++) begin
          s_act = (m_s2[c] == 1'b0);
          if (!enable) begin
            m_conf[c]  = 1'b0;
            m_ldone[c] = 1'b0;
            m_run[c]   = 0;
            m_held[c]  = 0;
          end else if (s_act != m_conf[c]) begin
            m_run[c]++;
            if (m_run[c] == CONFIRM_RUN) begin
              m_run[c]  = 0;
              m_conf[c] = s_act;
              if (s_act) begin
                m_pp[c]    = 1'b1;
                m_held[c]  = 0;
                m_ldone[c] = 1'b0;
              end else begin
                m_rp[c] = 1'b1;
              end
            end
          end else begin
            m_run[c] = 0;
            // Only samples preceded by a held sample advance the hold time.
            if (m_conf[c] && m_prev[c] == 1'b0 && !m_ldone[c]) begin
              m_held[c]++;
              if (m_held[c] == LONG_EDGES) begin
                m_lp[c]    = 1'b1;
                m_ldone[c] = 1'b1;
              end
            end
          end
        end
        m_prev = m_s2;
        m_s2   = m_s1;
        m_s1   = pad_n;
      end
    end
  end

  // Per-cycle compare against the model, plus pulse tallies for the directed checks.
  int pp_cnt[NP], rp_cnt[NP], lp_cnt[NP];

  initial begin : compare
    logic [4*NP:0] got_v, exp_v;
    for (int c = 0; c < NP; c++) begin
      pp_cnt[c] = 0; rp_cnt[c] = 0; lp_cnt[c] = 0;
    end
    forever begin
      @(negedge clk);
      got_v = {pressed, press_pulse, release_pulse, long_pulse, any_pressed};
      exp_v = {m_conf, m_pp, m_rp, m_lp, |m_conf};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t got %b expected %b (pressed,press,release,long,any)",
                 $time, got_v, exp_v);
      end
      for (int c = 0; c < NP; c++) begin
        pp_cnt[c] += int'(press_pulse[c]);
        rp_cnt[c] += int'(release_pulse[c]);
        lp_cnt[c] += int'(long_pulse[c]);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  // Wait for n rising edges and sample just after the last.
  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int snap_pp0, snap_rp0, snap_rp1, snap_lp1;

  initial begin : stimulus
    rst = 1'b1; enable = 1'b1; pad_n = 2'b11;
    after_edges(3);
    check("reset_outputs", int'({pressed, press_pulse, release_pulse, long_pulse, any_pressed}), 0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single press, latency 2**DB+2 edges
    pad_n[0] = 1'b0;
    after_edges(18); check("t1_no_press_e17", int'(press_pulse), 'b00);
    after_edges(1);  check("t1_press_e18", int'({pressed, press_pulse}), 'b0101);
    after_edges(1);  check("t1_pulse_one_cycle", int'({pressed, press_pulse}), 'b0100);
    @(negedge clk) pad_n[0] = 1'b1;
    repeat (22) @(negedge clk);

    // 2: short glitch ignored, long enough low accepted once
    snap_pp0 = pp_cnt[0];
    pad_n[0] = 1'b0;
    repeat (10) @(negedge clk);
    pad_n[0] = 1'b1;
    repeat (20) @(negedge clk);
    after_edges(1);
    check("t2_glitch_no_press", pp_cnt[0] - snap_pp0, 0);
    @(negedge clk) pad_n[0] = 1'b0;
    repeat (20) @(negedge clk);
    pad_n[0] = 1'b1;
    repeat (25) @(negedge clk);
    after_edges(1);
    check("t2_one_press", pp_cnt[0] - snap_pp0, 1);

    // 3: long press on channel 1, then timed release
    snap_lp1 = lp_cnt[1];
    @(negedge clk) pad_n[1] = 1'b0;
    after_edges(19); check("t3_press_e18", int'(press_pulse), 'b10);
    after_edges(63); check("t3_no_long_e81", int'(long_pulse), 'b00);
    after_edges(1);  check("t3_long_e82", int'(long_pulse), 'b10);
    after_edges(1);  check("t3_long_one_cycle", int'(long_pulse), 'b00);
    repeat (17) @(negedge clk);
    pad_n[1] = 1'b1;
    check("t3_long_once", lp_cnt[1] - snap_lp1, 1);
    after_edges(18); check("t3_no_release_r17", int'(release_pulse), 'b00);
    after_edges(1);  check("t3_release_r18", int'({pressed, release_pulse}), 'b0010);
    repeat (4) @(negedge clk);

    // 4: release bounce while held; hold timer resumes where it left off
    snap_rp0 = rp_cnt[0];
    @(negedge clk) pad_n[0] = 1'b0;
    after_edges(31);
    @(negedge clk) pad_n[0] = 1'b1;
    repeat (5) @(negedge clk);
    pad_n[0] = 1'b0;
    after_edges(47); check("t4_no_long_e82", int'(long_pulse), 'b00);
    check("t4_still_pressed", int'(pressed), 'b01);
    check("t4_no_release", rp_cnt[0] - snap_rp0, 0);
    after_edges(5);  check("t4_no_long_e87", int'(long_pulse), 'b00);
    after_edges(1);  check("t4_long_e88", int'(long_pulse), 'b01);
    @(negedge clk) pad_n[0] = 1'b1;
    repeat (22) @(negedge clk);

    // 5: simultaneous press, disable, re-enable re-confirms
    snap_rp0 = rp_cnt[0]; snap_rp1 = rp_cnt[1];
    pad_n = 2'b00;
    after_edges(19); check("t5_both_press", int'({press_pulse, any_pressed}), 'b111);
    after_edges(5);
    @(negedge clk) enable = 1'b0;
    after_edges(1);
    check("t5_disabled_outputs", int'({pressed, press_pulse, release_pulse, long_pulse, any_pressed}), 0);
    repeat (20) @(negedge clk);
    check("t5_no_release", (rp_cnt[0] - snap_rp0) + (rp_cnt[1] - snap_rp1), 0);
    enable = 1'b1;
    after_edges(16); check("t5_reenable_e15", int'(press_pulse), 'b00);
    after_edges(1);  check("t5_reenable_press", int'(press_pulse), 'b11);
    @(negedge clk) pad_n = 2'b11;
    repeat (22) @(negedge clk);

    // 6: async reset mid-confirmation, then a full fresh confirmation
    pad_n[1] = 1'b0;
    repeat (22) @(negedge clk);
    pad_n[0] = 1'b0;
    after_edges(10);
    #2 rst = 1'b1;
    #1 check("t6_async_reset", int'({pressed, any_pressed}), 0);
    @(negedge clk) rst = 1'b0;
    after_edges(18); check("t6_no_press_e17", int'(press_pulse), 'b00);
    after_edges(1);  check("t6_press_e18", int'(press_pulse), 'b11);
    @(negedge clk) pad_n = 2'b11;
    repeat (22) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
